// File: rtl/mem_access_unit.sv
// Request-side master for a 256x16 data memory: accepts load/store requests,
// drives the memory pins, and returns load words (with bursts) under backpressure.
module mem_access_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [BURST_W-1:0] req_burst,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_last,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  write_data,
  input  logic [DATA_W-1:0]  read_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // cnt holds the number of words still to read after the current one.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !reset) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = req_burst;
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        rsp_data_d  = read_data;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (cnt_q == '0);
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - BURST_W'(1);
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory pins are a pure decode of state, so an async reset kills a write at once.
  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    case (state_q)
      WRITE: begin
        mem_write  = 1'b1;
        address    = addr_q;
        write_data = wdata_q;
      end
      READ: begin
        mem_read = 1'b1;
        address  = addr_q;
      end
      default: ;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random bench for mem_access_unit with a behavioural 256x16 memory
// and a response scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_burst;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [15:0] rsp_data;
  logic        mem_read, mem_write;
  logic [7:0]  address;
  logic [15:0] write_data, read_data;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_burst(req_burst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign read_data = mem[address];
  always @(posedge clk) if (mem_write) mem[address] <= write_data;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 50000 cycles");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("excl_rd_wr", {31'd0, mem_read & mem_write}, 32'd0);
  endtask

  task automatic do_store(input logic [7:0] a, input logic [15:0] d);
    check("st_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    req_burst = 3'($urandom);
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    check("st_mem_write", mem_write, 1);
    check("st_address", address, a);
    check("st_wdata", write_data, d);
    check("st_req_ready_busy", req_ready, 0);
    ref_mem[a] = d;
    tick();
    check("st_write_one_cycle", mem_write, 0);
    check("st_idle_address", address, 0);
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [2:0] b);
    logic [7:0] ea;
    exp_t e;
    for (int i = 0; i <= int'(b); i++) begin
      ea = a + 8'(i);
      e.data = ref_mem[ea];
      e.last = (i == int'(b));
      exp_q.push_back(e);
    end
  endtask

  // Entered at the negedge of the first READ cycle; leaves at the negedge after the last transfer.
  task automatic load_seq(input logic [7:0] a, input logic [2:0] b);
    logic [7:0] ea;
    exp_t e;
    rsp_ready = 1'b1;
    for (int i = 0; i <= int'(b); i++) begin
      ea = a + 8'(i);
      check("rd_mem_read", mem_read, 1);
      check("rd_address", address, ea);
      check("rd_rsp_valid_low", rsp_valid, 0);
      check("rd_req_ready", req_ready, 0);
      tick();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_mem_read", mem_read, 0);
      check("hold_req_ready", req_ready, 0);
      check("sb_not_empty", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_last", rsp_last, e.last);
      end
      tick();
    end
    check("ld_done_req_ready", req_ready, 1);
  endtask

  task automatic issue_load(input logic [7:0] a, input logic [2:0] b);
    check("ld_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_burst = b;
    req_wdata = 16'($urandom);
    push_exp(a, b);
    tick();
    req_valid = 1'b0;
    load_seq(a, b);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_burst = '0; rsp_ready = 1'b1;

    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_address", address, 0);
    check("rst_write_data", write_data, 0);
    reset = 1'b0;
    tick();
    check("post_rst_req_ready", req_ready, 1);

    // Round trip: store then load in the very next idle cycle
    $display("[TB] store/load round trip");
    do_store(8'h10, 16'hBEEF);
    issue_load(8'h10, 3'd0);

    $display("[TB] burst with address wrap");
    do_store(8'hFE, 16'h1111);
    do_store(8'hFF, 16'h2222);
    do_store(8'h00, 16'h3333);
    issue_load(8'hFE, 3'd2);

    $display("[TB] backpressure");
    do_store(8'h20, 16'hA5A5);
    do_store(8'h21, 16'h5A5A);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20; req_burst = 3'd1;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check("bp_mem_read", mem_read, 1);
    tick();
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_data", rsp_data, 16'hA5A5);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_stall_valid", rsp_valid, 1);
      check("bp_stall_data", rsp_data, 16'hA5A5);
      check("bp_stall_last", rsp_last, 0);
      check("bp_stall_mem_read", mem_read, 0);
      check("bp_stall_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_w2_mem_read", mem_read, 1);
    check("bp_w2_address", address, 8'h21);
    check("bp_w2_req_ready", req_ready, 0);
    tick();
    check("bp_w2_data", rsp_data, 16'h5A5A);
    check("bp_w2_last", rsp_last, 1);
    check("bp_w2_req_ready", req_ready, 0);
    tick();
    check("bp_done_req_ready", req_ready, 1);
    check("bp_done_rsp_valid", rsp_valid, 0);

    $display("[TB] request while busy");
    for (int i = 0; i < 4; i++) do_store(8'(8'h30 + i), 16'(16'hC000 + i));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30; req_burst = 3'd3;
    push_exp(8'h30, 3'd3);
    tick();
    req_addr = 8'h10; req_burst = 3'd0;
    push_exp(8'h10, 3'd0);
    load_seq(8'h30, 3'd3);
    tick();
    req_valid = 1'b0;
    load_seq(8'h10, 3'd0);

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 4; i++) do_store(8'(8'h40 + i), 16'(16'hD000 + i));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40; req_burst = 3'd3;
    tick();
    req_valid = 1'b0;
    check("rb_w1_address", address, 8'h40);
    tick();
    check("rb_w1_data", rsp_data, 16'hD000);
    check("rb_w1_last", rsp_last, 0);
    tick();
    check("rb_w2_address", address, 8'h41);
    tick();
    check("rb_w2_valid", rsp_valid, 1);
    check("rb_w2_data", rsp_data, 16'hD001);
    #2 reset = 1'b1;
    #1;
    check("rb_async_rsp_valid", rsp_valid, 0);
    check("rb_async_mem_read", mem_read, 0);
    check("rb_async_mem_write", mem_write, 0);
    check("rb_async_req_ready", req_ready, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    check("rb_after_req_ready", req_ready, 1);
    check("rb_after_rsp_data", rsp_data, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rb_quiet_rsp_valid", rsp_valid, 0);
      check("rb_quiet_mem_read", mem_read, 0);
    end

    $display("[TB] reset during write");
    do_store(8'h50, 16'h1234);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h50; req_wdata = 16'h5555;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    check("rw_mem_write", mem_write, 1);
    #2 reset = 1'b1;
    #1;
    check("rw_abort_mem_write", mem_write, 0);
    check("rw_abort_address", address, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    issue_load(8'h50, 3'd0);

    $display("[TB] random mix");
    for (int i = 0; i < 16; i++) do_store(8'(i), 16'($urandom));
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_store(8'($urandom_range(0, 15)), 16'($urandom));
      else
        issue_load(8'($urandom_range(0, 12)), 3'($urandom_range(0, 3)));
    end

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Request-side master for the 256 x 16-bit data memory (combinational read, posedge write). The block accepts load/store commands from the datapath over a valid/ready request channel and drives the memory's `mem_read`/`mem_write`/`address`/`write_data` pins. It returns load data, including short sequential bursts, over a valid/ready response channel with backpressure. It sits between the core's execute stage (or a DMA-style client) and the data memory.

## Interface
Parameters:
- `ADDR_W`, 8, address width (memory depth 2^ADDR_W words)
- `DATA_W`, 16, word width
- `BURST_W`, 3, width of burst-length field (max burst 2^BURST_W words)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  start word address
- `req_wdata`  in  DATA_W  store data (ignored for loads)
- `req_burst`  in  BURST_W  load burst length minus 1 (ignored for stores)
- `rsp_valid`  out  1  load data word valid
- `rsp_ready`  in  1  consumer accepts the response word
- `rsp_data`  out  DATA_W  load data
- `rsp_last`  out  1  final word of the current burst
- `mem_read`  out  1  to memory read enable
- `mem_write`  out  1  to memory write enable
- `address`  out  ADDR_W  to memory address
- `write_data`  out  DATA_W  to memory write data
- `read_data`  in  DATA_W  from memory, combinational read result

## Operation
- FSM states: IDLE, WRITE, READ, HOLD. Reset state: IDLE.
- `req_ready` = (state == IDLE) & ~`reset`. A handshake is `req_valid & req_ready` sampled at a rising edge.
- IDLE: on handshake, latch addr, wdata, and burst into `cnt`. Go to WRITE if `req_write`, else READ.
- WRITE (exactly 1 cycle):
  - `mem_write`=1, `address`=latched addr, `write_data`=latched wdata.
  - Memory commits at the end of this cycle.
  - Next state: IDLE. Stores generate no response.
- READ (exactly 1 cycle):
  - `mem_read`=1, `address`=current addr.
  - At the edge: `rsp_data`<=`read_data`, `rsp_valid`<=1, `rsp_last`<=(`cnt`==0).
  - Next state: HOLD.
- HOLD: `rsp_valid` held at 1, with `rsp_data` and `rsp_last` stable, until `rsp_ready`. On the `rsp_valid & rsp_ready` edge:
  - `rsp_valid`<=0.
  - If `rsp_last`, go to IDLE.
  - Else addr<=addr+1 (mod 2^ADDR_W), `cnt`<=`cnt`-1, go to READ.
- Address wrap: a burst crossing 255 continues at 0. No error is flagged.
- Memory outputs are a decode of the registered state and latched fields:
  - `mem_read` and `mem_write` are never both 1.
  - In IDLE and HOLD, both enables are 0, and `address`/`write_data` are 0.
- A new request is never accepted while a store or a burst is in flight; `req_ready`=0 outside IDLE.
- Reset values:
  - State IDLE.
  - `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0.
  - `mem_read`=0, `mem_write`=0, `address`=0, `write_data`=0.
  - `req_ready`=0 while `reset` is high.
- Reset mid-operation (any state) aborts immediately:
  - A WRITE cycle cut short by reset before its rising edge does not commit.
  - A pending response is dropped (`rsp_valid`→0 asynchronously).

## Timing
- Store: handshake at edge E0; WRITE during cycle E0–E1; memory updated at E1; `req_ready`=1 again after E1. Throughput is 1 store per 2 cycles.
- Load: handshake at E0; READ during E0–E1; `rsp_valid`=1 after E1. That is a 1-cycle latency from acceptance to first valid data.
- Burst, with `rsp_ready` held high: words appear every 2 cycles (READ, HOLD alternating). N words finish N*2 cycles after the handshake. IDLE follows the last transfer edge.
- Backpressure: each extra cycle of `rsp_ready`=0 extends HOLD by one cycle. Memory is not re-read during stalls.
- Read-after-write: a load accepted the cycle after a store's WRITE cycle returns the newly written value.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.

## Test plan
- Store/load round trip: store 0xBEEF @ 0x10, then load @ 0x10 (burst 0) → `mem_write`=1 for exactly one cycle with `address`=0x10; `rsp_data`=0xBEEF, `rsp_last`=1, `rsp_valid` rises 1 cycle after load acceptance.
- Burst with wrap: preload 0xFE=0x1111, 0xFF=0x2222, 0x00=0x3333; load @ 0xFE with `req_burst`=2 → three responses 0x1111, 0x2222, 0x3333; `rsp_last` only on the third; `address` sequence 0xFE, 0xFF, 0x00.
- Backpressure: load burst 1 @ 0x20 with `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_data` stable for all 5; `mem_read`=0 during the stall; `req_ready`=0 until after the second word transfers.
- Request while busy: hold `req_valid`=1 during a 4-word burst → `req_ready`=0 throughout; the second request is accepted only in the first IDLE cycle after `rsp_last` transfers.
- Reset mid-burst: assert `reset` during HOLD of word 2 of 4 → `rsp_valid`, `mem_read`, `mem_write`, and `req_ready` go to 0 immediately; after release, state is IDLE, `req_ready`=1, and no further responses are issued.
- Exclusivity check: random mix of 200 stores and loads → `mem_read & mem_write` never 1; every load returns the last value stored to that address (scoreboard model).
